// File: rtl/yazmac_okuma_asamasi_pkg.sv
// Shared constants for the operand-read / issue stage.
// Register address width comes from the HY_BIT define (default 5).
`ifndef HY_BIT
`define HY_BIT 5
`endif

package yazmac_okuma_asamasi_pkg;

  localparam int unsigned HY_BIT              = `HY_BIT;
  localparam int unsigned VERI_BIT_VARSAYILAN = 32;
  localparam int unsigned YAZMAC_SAYISI       = 1 << `HY_BIT;
  localparam logic [HY_BIT-1:0] X0_ADRES      = '0;

  function automatic logic sifir_mi(input logic [HY_BIT-1:0] adres);
    return adres == X0_ADRES;
  endfunction

endpackage

// File: rtl/yazmac_okuma_asamasi_skor_tablosu.sv
// In-flight destination scoreboard: one bit per register, set on issue,
// cleared on writeback, with three combinational busy lookups.
module yazmac_okuma_asamasi_skor_tablosu
  import yazmac_okuma_asamasi_pkg::*;
(
  input  logic              clk_g,
  input  logic              rst_g,
  input  logic              ata_g,
  input  logic [HY_BIT-1:0] ata_adres_g,
  input  logic              sil_g,
  input  logic [HY_BIT-1:0] sil_adres_g,
  input  logic [HY_BIT-1:0] sorgu1_adres_g,
  input  logic [HY_BIT-1:0] sorgu2_adres_g,
  input  logic [HY_BIT-1:0] sorgu3_adres_g,
  output logic              mesgul1_c,
  output logic              mesgul2_c,
  output logic              mesgul3_c
);

  logic [YAZMAC_SAYISI-1:0] sb_q, sb_d;

  // Clear first so that a set to the same register wins.
  always_comb begin
    sb_d = sb_q;
    if (sil_g && !sifir_mi(sil_adres_g)) sb_d[sil_adres_g] = 1'b0;
    if (ata_g && !sifir_mi(ata_adres_g)) sb_d[ata_adres_g] = 1'b1;
  end

  always_ff @(posedge clk_g) begin
    if (rst_g) sb_q <= '0;
    else       sb_q <= sb_d;
  end

  assign mesgul1_c = sb_q[sorgu1_adres_g];
  assign mesgul2_c = sb_q[sorgu2_adres_g];
  assign mesgul3_c = sb_q[sorgu3_adres_g];

endmodule

// File: rtl/yazmac_okuma_asamasi.sv
// Operand-read / issue stage with RAW/WAW scoreboard stalls.
// Define GY_ATLATMA_EN to bypass writeback data straight into the operands.
module yazmac_okuma_asamasi
  import yazmac_okuma_asamasi_pkg::*;
#(
  parameter int unsigned VERI_BIT = VERI_BIT_VARSAYILAN,
  parameter int unsigned KOD_BIT  = 16
) (
  input  logic                clk_g,
  input  logic                rst_g,
  input  logic                coz_gecerli_g,
  output logic                coz_hazir_c,
  input  logic [HY_BIT-1:0]   coz_ky1_adres_g,
  input  logic [HY_BIT-1:0]   coz_ky2_adres_g,
  input  logic [HY_BIT-1:0]   coz_hy_adres_g,
  input  logic                coz_hy_yaz_g,
  input  logic [KOD_BIT-1:0]  coz_kontrol_g,
  output logic [HY_BIT-1:0]   rf_ky1_adres_c,
  output logic [HY_BIT-1:0]   rf_ky2_adres_c,
  input  logic [VERI_BIT-1:0] rf_ky1_deger_g,
  input  logic [VERI_BIT-1:0] rf_ky2_deger_g,
  input  logic                gy_yaz_g,
  input  logic [HY_BIT-1:0]   gy_adres_g,
  input  logic [VERI_BIT-1:0] gy_deger_g,
  input  logic                temizle_g,
  output logic                yur_gecerli_c,
  input  logic                yur_hazir_g,
  output logic [VERI_BIT-1:0] yur_ky1_deger_c,
  output logic [VERI_BIT-1:0] yur_ky2_deger_c,
  output logic [HY_BIT-1:0]   yur_hy_adres_c,
  output logic                yur_hy_yaz_c,
  output logic [KOD_BIT-1:0]  yur_kontrol_c
);

`ifdef GY_ATLATMA_EN
  localparam logic AtlatmaEn = 1'b1;
`else
  localparam logic AtlatmaEn = 1'b0;
`endif

  logic                yur_gecerli_q, yur_hy_yaz_q;
  logic [VERI_BIT-1:0] yur_ky1_q, yur_ky2_q;
  logic [HY_BIT-1:0]   yur_hy_adres_q;
  logic [KOD_BIT-1:0]  yur_kontrol_q;

  logic sb_ky1, sb_ky2, sb_hy;
  logic atla1, atla2, yur_ky1_ayni, yur_ky2_ayni, yur_hy_ayni;
  logic mesgul1, mesgul2, mesgul_hy, tehlike, kabul, ihrac;
  logic [VERI_BIT-1:0] ky1_deger, ky2_deger;

  assign rf_ky1_adres_c = coz_ky1_adres_g;
  assign rf_ky2_adres_c = coz_ky2_adres_g;

  assign atla1 = AtlatmaEn && gy_yaz_g && (gy_adres_g == coz_ky1_adres_g)
                 && !sifir_mi(coz_ky1_adres_g);
  assign atla2 = AtlatmaEn && gy_yaz_g && (gy_adres_g == coz_ky2_adres_g)
                 && !sifir_mi(coz_ky2_adres_g);

  assign ky1_deger = sifir_mi(coz_ky1_adres_g) ? '0 : (atla1 ? gy_deger_g : rf_ky1_deger_g);
  assign ky2_deger = sifir_mi(coz_ky2_adres_g) ? '0 : (atla2 ? gy_deger_g : rf_ky2_deger_g);

  // A writer still sitting in the output register has not reached the scoreboard yet.
  assign yur_ky1_ayni = yur_gecerli_q && yur_hy_yaz_q && (yur_hy_adres_q == coz_ky1_adres_g);
  assign yur_ky2_ayni = yur_gecerli_q && yur_hy_yaz_q && (yur_hy_adres_q == coz_ky2_adres_g);
  assign yur_hy_ayni  = yur_gecerli_q && yur_hy_yaz_q && (yur_hy_adres_q == coz_hy_adres_g);

  assign mesgul1   = !sifir_mi(coz_ky1_adres_g) && ((sb_ky1 && !atla1) || yur_ky1_ayni);
  assign mesgul2   = !sifir_mi(coz_ky2_adres_g) && ((sb_ky2 && !atla2) || yur_ky2_ayni);
  assign mesgul_hy = coz_hy_yaz_g && !sifir_mi(coz_hy_adres_g) && (sb_hy || yur_hy_ayni);
  assign tehlike   = coz_gecerli_g && (mesgul1 || mesgul2 || mesgul_hy);

  assign coz_hazir_c = (!yur_gecerli_q || yur_hazir_g) && !tehlike && !temizle_g;
  assign kabul       = coz_gecerli_g && coz_hazir_c;
  // A flushed instruction never counts as issued.
  assign ihrac       = yur_gecerli_q && yur_hazir_g && !temizle_g && yur_hy_yaz_q
                       && !sifir_mi(yur_hy_adres_q);

  yazmac_okuma_asamasi_skor_tablosu u_skor (
    .clk_g          (clk_g),
    .rst_g          (rst_g),
    .ata_g          (ihrac),
    .ata_adres_g    (yur_hy_adres_q),
    .sil_g          (gy_yaz_g),
    .sil_adres_g    (gy_adres_g),
    .sorgu1_adres_g (coz_ky1_adres_g),
    .sorgu2_adres_g (coz_ky2_adres_g),
    .sorgu3_adres_g (coz_hy_adres_g),
    .mesgul1_c      (sb_ky1),
    .mesgul2_c      (sb_ky2),
    .mesgul3_c      (sb_hy)
  );

  always_ff @(posedge clk_g) begin
    if (rst_g) begin
      yur_gecerli_q  <= 1'b0;
      yur_ky1_q      <= '0;
      yur_ky2_q      <= '0;
      yur_hy_adres_q <= '0;
      yur_hy_yaz_q   <= 1'b0;
      yur_kontrol_q  <= '0;
    end else if (temizle_g) begin
      yur_gecerli_q  <= 1'b0;
    end else if (kabul) begin
      yur_gecerli_q  <= 1'b1;
      yur_ky1_q      <= ky1_deger;
      yur_ky2_q      <= ky2_deger;
      yur_hy_adres_q <= coz_hy_adres_g;
      yur_hy_yaz_q   <= coz_hy_yaz_g;
      yur_kontrol_q  <= coz_kontrol_g;
    end else if (yur_gecerli_q && yur_hazir_g) begin
      yur_gecerli_q  <= 1'b0;
    end
  end

  assign yur_gecerli_c   = yur_gecerli_q;
  assign yur_ky1_deger_c = yur_ky1_q;
  assign yur_ky2_deger_c = yur_ky2_q;
  assign yur_hy_adres_c  = yur_hy_adres_q;
  assign yur_hy_yaz_c    = yur_hy_yaz_q;
  assign yur_kontrol_c   = yur_kontrol_q;

endmodule

// File: tb/tb_yazmac_okuma_asamasi.sv
// Directed bench for yazmac_okuma_asamasi; follows GY_ATLATMA_EN when defined.
module tb_yazmac_okuma_asamasi;
  import yazmac_okuma_asamasi_pkg::*;

  logic              clk_g = 1'b0;
  logic              rst_g;
  logic              coz_gecerli_g, coz_hazir_c, coz_hy_yaz_g;
  logic [HY_BIT-1:0] coz_ky1_adres_g, coz_ky2_adres_g, coz_hy_adres_g;
  logic [15:0]       coz_kontrol_g;
  logic [HY_BIT-1:0] rf_ky1_adres_c, rf_ky2_adres_c;
  logic [31:0]       rf_ky1_deger_g, rf_ky2_deger_g;
  logic              gy_yaz_g;
  logic [HY_BIT-1:0] gy_adres_g;
  logic [31:0]       gy_deger_g;
  logic              temizle_g, yur_gecerli_c, yur_hazir_g, yur_hy_yaz_c;
  logic [31:0]       yur_ky1_deger_c, yur_ky2_deger_c;
  logic [HY_BIT-1:0] yur_hy_adres_c;
  logic [15:0]       yur_kontrol_c;

  logic [31:0] rf_mem [YAZMAC_SAYISI];
  int checks = 0;
  int errors = 0;

  always #5 clk_g = ~clk_g;

  // Register file model: x0 deliberately reads garbage.
  always @(posedge clk_g) begin
    if (rst_g) begin
      for (int i = 0; i < YAZMAC_SAYISI; i++) rf_mem[i] <= 32'hA000_0000 | i;
      rf_mem[0] <= 32'hDEAD_BEEF;
    end else if (gy_yaz_g && gy_adres_g != 0) begin
      rf_mem[gy_adres_g] <= gy_deger_g;
    end
  end
  assign rf_ky1_deger_g = rf_mem[rf_ky1_adres_c];
  assign rf_ky2_deger_g = rf_mem[rf_ky2_adres_c];

  yazmac_okuma_asamasi #(.VERI_BIT(32), .KOD_BIT(16)) dut (
    .clk_g           (clk_g),
    .rst_g           (rst_g),
    .coz_gecerli_g   (coz_gecerli_g),
    .coz_hazir_c     (coz_hazir_c),
    .coz_ky1_adres_g (coz_ky1_adres_g),
    .coz_ky2_adres_g (coz_ky2_adres_g),
    .coz_hy_adres_g  (coz_hy_adres_g),
    .coz_hy_yaz_g    (coz_hy_yaz_g),
    .coz_kontrol_g   (coz_kontrol_g),
    .rf_ky1_adres_c  (rf_ky1_adres_c),
    .rf_ky2_adres_c  (rf_ky2_adres_c),
    .rf_ky1_deger_g  (rf_ky1_deger_g),
    .rf_ky2_deger_g  (rf_ky2_deger_g),
    .gy_yaz_g        (gy_yaz_g),
    .gy_adres_g      (gy_adres_g),
    .gy_deger_g      (gy_deger_g),
    .temizle_g       (temizle_g),
    .yur_gecerli_c   (yur_gecerli_c),
    .yur_hazir_g     (yur_hazir_g),
    .yur_ky1_deger_c (yur_ky1_deger_c),
    .yur_ky2_deger_c (yur_ky2_deger_c),
    .yur_hy_adres_c  (yur_hy_adres_c),
    .yur_hy_yaz_c    (yur_hy_yaz_c),
    .yur_kontrol_c   (yur_kontrol_c)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic adim();
    @(posedge clk_g);
    #1;
  endtask

  task automatic coz(input logic v, input logic [4:0] k1, input logic [4:0] k2,
                     input logic [4:0] hy, input logic yaz, input logic [15:0] kod);
    coz_gecerli_g   = v;
    coz_ky1_adres_g = k1;
    coz_ky2_adres_g = k2;
    coz_hy_adres_g  = hy;
    coz_hy_yaz_g    = yaz;
    coz_kontrol_g   = kod;
  endtask

  task automatic gy(input logic yaz, input logic [4:0] adr, input logic [31:0] deger);
    gy_yaz_g   = yaz;
    gy_adres_g = adr;
    gy_deger_g = deger;
  endtask

  initial begin
    rst_g = 1'b1;
    temizle_g = 1'b0;
    yur_hazir_g = 1'b1;
    coz(0, 0, 0, 0, 0, 16'h0);
    gy(0, 0, 32'h0);
    repeat (2) adim();
    rst_g = 1'b0;

    // Reset state
    chk("rst_gecerli", yur_gecerli_c, 0);
    chk("rst_hazir", coz_hazir_c, 1);
    chk("rst_ky1", yur_ky1_deger_c, 0);
    chk("rst_ky2", yur_ky2_deger_c, 0);
    chk("rst_hy", yur_hy_adres_c, 0);
    chk("rst_hy_yaz", yur_hy_yaz_c, 0);
    chk("rst_kontrol", yur_kontrol_c, 0);
    chk("rst_sb", dut.u_skor.sb_q, 0);

    // RAW on x5, resolved by writeback
    coz(1, 1, 2, 5, 1, 16'h0011);
    #1 chk("rf_adres", rf_ky1_adres_c, 1);
    chk("a_hazir", coz_hazir_c, 1);
    adim();
    chk("a_gecerli", yur_gecerli_c, 1);
    chk("a_ky1", yur_ky1_deger_c, 32'hA000_0001);
    chk("a_ky2", yur_ky2_deger_c, 32'hA000_0002);
    chk("a_hy", yur_hy_adres_c, 5);
    chk("a_kontrol", yur_kontrol_c, 16'h0011);
    coz(1, 5, 0, 6, 1, 16'h0022);
    #1 chk("a_stall_yur", coz_hazir_c, 0);
    adim();
    chk("a_bosalma", yur_gecerli_c, 0);
    chk("a_stall_sb", coz_hazir_c, 0);
    adim();
    chk("a_stall_sb2", coz_hazir_c, 0);
    gy(1, 5, 32'h0000_1234);
`ifdef GY_ATLATMA_EN
    #1 chk("a_atla_hazir", coz_hazir_c, 1);
    adim();
    gy(0, 0, 32'h0);
`else
    #1 chk("a_gy_hala_stall", coz_hazir_c, 0);
    adim();
    gy(0, 0, 32'h0);
    #1 chk("a_sonra_hazir", coz_hazir_c, 1);
    adim();
`endif
    chk("a_okuyucu_gecerli", yur_gecerli_c, 1);
    chk("a_okuyucu_ky1", yur_ky1_deger_c, 32'h0000_1234);
    chk("a_okuyucu_ky2", yur_ky2_deger_c, 0);
    chk("a_okuyucu_hy", yur_hy_adres_c, 6);
    coz(0, 0, 0, 0, 0, 16'h0);
    adim();
    gy(1, 6, 32'h66);
    adim();
    gy(0, 0, 32'h0);

    // x0 reads zero and is never busy
    coz(1, 0, 0, 0, 1, 16'h0033);
    #1 chk("b_hazir", coz_hazir_c, 1);
    adim();
    chk("b_ky1_sifir", yur_ky1_deger_c, 0);
    chk("b_ky2_sifir", yur_ky2_deger_c, 0);
    coz(1, 0, 0, 0, 1, 16'h0044);
    #1 chk("b_x0_mesgul_degil", coz_hazir_c, 1);
    adim();
    chk("b_kontrol", yur_kontrol_c, 16'h0044);
    chk("b_gecerli", yur_gecerli_c, 1);
    coz(0, 0, 0, 0, 0, 16'h0);
    adim();
    chk("b_sb_bos", dut.u_skor.sb_q, 0);

    // Back-pressure for three cycles, then no bubble
    yur_hazir_g = 1'b0;
    coz(1, 1, 2, 10, 1, 16'h0055);
    adim();
    coz(1, 3, 4, 11, 1, 16'h0066);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("c_hazir", coz_hazir_c, 0);
      chk("c_kontrol", yur_kontrol_c, 16'h0055);
      chk("c_hy", yur_hy_adres_c, 10);
      chk("c_ky1", yur_ky1_deger_c, 32'hA000_0001);
      chk("c_gecerli", yur_gecerli_c, 1);
      adim();
    end
    yur_hazir_g = 1'b1;
    #1 chk("c_birak_hazir", coz_hazir_c, 1);
    adim();
    chk("c_kabarcik_yok", yur_gecerli_c, 1);
    chk("c_kontrol2", yur_kontrol_c, 16'h0066);
    chk("c_ky1_2", yur_ky1_deger_c, 32'hA000_0003);
    coz(0, 0, 0, 0, 0, 16'h0);
    adim();
    gy(1, 10, 32'h10);
    adim();
    gy(1, 11, 32'h11);
    adim();
    gy(0, 0, 32'h0);

    // WAW on x7
    coz(1, 1, 2, 7, 1, 16'h0077);
    #1 chk("d_w1_hazir", coz_hazir_c, 1);
    adim();
    coz(1, 3, 4, 7, 1, 16'h0078);
    #1 chk("d_waw_yur", coz_hazir_c, 0);
    adim();
    chk("d_waw_sb", coz_hazir_c, 0);
    chk("d_sb7_w1", dut.u_skor.sb_q[7], 1);
    gy(1, 7, 32'h77);
    #1 chk("d_waw_gy", coz_hazir_c, 0);
    adim();
    gy(0, 0, 32'h0);
    #1 chk("d_w2_hazir", coz_hazir_c, 1);
    adim();
    chk("d_w2_kontrol", yur_kontrol_c, 16'h0078);
    coz(0, 0, 0, 0, 0, 16'h0);
    adim();
    chk("d_sb7", dut.u_skor.sb_q[7], 1);

    // Flush of a valid output register holding hy=9
    coz(1, 1, 2, 9, 1, 16'h0099);
    #1 chk("e_hazir", coz_hazir_c, 1);
    adim();
    chk("e_hy", yur_hy_adres_c, 9);
    temizle_g = 1'b1;
    coz(1, 3, 0, 12, 1, 16'h00AA);
    #1 chk("e_temizle_hazir", coz_hazir_c, 0);
    adim();
    temizle_g = 1'b0;
    chk("e_gecerli", yur_gecerli_c, 0);
    chk("e_sb9", dut.u_skor.sb_q[9], 0);
    chk("e_kabul_yok", yur_kontrol_c, 16'h0099);
    coz(0, 0, 0, 0, 0, 16'h0);

    // Mid-operation reset beats a pending accept
    coz(1, 1, 2, 13, 1, 16'h00BB);
    adim();
    chk("f_gecerli", yur_gecerli_c, 1);
    rst_g = 1'b1;
    adim();
    rst_g = 1'b0;
    coz(0, 0, 0, 0, 0, 16'h0);
    chk("f_rst_gecerli", yur_gecerli_c, 0);
    chk("f_rst_kontrol", yur_kontrol_c, 0);
    chk("f_rst_ky1", yur_ky1_deger_c, 0);
    chk("f_rst_sb", dut.u_skor.sb_q, 0);
    gy(1, 7, 32'h7);
    adim();
    gy(0, 0, 32'h0);
    chk("f_gy_noop", dut.u_skor.sb_q, 0);
    #1 chk("f_hazir", coz_hazir_c, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/yazmac_okuma_asamasi.md
Name: yazmac_okuma_asamasi

Overview:
- Operand-read / issue stage between decode and execute.
- Drives the register file read addresses and captures source operands into a pipeline register for execute.
- Tracks destination registers still in flight with a scoreboard and stalls decode on RAW/WAW hazards.
- Observes the writeback port (the same signals that drive the register file write) to clear the scoreboard and, optionally, to bypass.

Parameters:
- VERI_BIT, 32, operand/data width.
- KOD_BIT, 16, width of the opaque control payload passed to execute.
- Register address width is the shared `HY_BIT` definition (5).

Ports:
- clk_g  in  1  clock
- rst_g  in  1  synchronous active-high reset
- coz_gecerli_g  in  1  decode instruction valid
- coz_hazir_c  out  1  stage accepts decode instruction
- coz_ky1_adres_g / coz_ky2_adres_g  in  HY_BIT  source register addresses
- coz_hy_adres_g  in  HY_BIT  destination address
- coz_hy_yaz_g  in  1  instruction writes its destination
- coz_kontrol_g  in  KOD_BIT  opaque control payload
- rf_ky1_adres_c / rf_ky2_adres_c  out  HY_BIT  register file read addresses
- rf_ky1_deger_g / rf_ky2_deger_g  in  VERI_BIT  register file read data (combinational)
- gy_yaz_g  in  1  writeback write enable
- gy_adres_g  in  HY_BIT  writeback address
- gy_deger_g  in  VERI_BIT  writeback data
- temizle_g  in  1  flush (redirect)
- yur_gecerli_c  out  1  execute-side valid
- yur_hazir_g  in  1  execute accepts
- yur_ky1_deger_c / yur_ky2_deger_c  out  VERI_BIT  captured operands
- yur_hy_adres_c  out  HY_BIT  destination address
- yur_hy_yaz_c  out  1  destination write flag
- yur_kontrol_c  out  KOD_BIT  payload

Behaviour:
- Reset (rst_g=1 at posedge): yur_gecerli_c=0, all yur_* data outputs=0, scoreboard all 0. Applies mid-operation; writebacks after reset for cleared registers are no-ops.
- rf_ky*_adres_c = coz_ky*_adres_g, purely combinational.
- Operand rule: address 0 gives 0 regardless of rf data. Otherwise the rf value (or the bypass value, see Optional Feature).
- Busy(r), r≠0: sb[r]=1 OR (yur_gecerli_c AND yur_hy_yaz_c AND yur_hy_adres_c==r). Register 0 is never busy.
- Hazard: coz_gecerli_g AND any of:
  - Busy(ky1)
  - Busy(ky2)
  - coz_hy_yaz_g AND Busy(hy), which is a WAW stall.
- coz_hazir_c = (!yur_gecerli_c OR yur_hazir_g) AND !hazard AND !temizle_g. This is combinational from the coz_* inputs.
- Accept (coz_gecerli_g AND coz_hazir_c): the output register loads operands, hy, hy_yaz and kontrol, and sets yur_gecerli_c=1 next cycle. Latency is 1 cycle from decode to execute.
- If yur_gecerli_c AND yur_hazir_g AND no accept: yur_gecerli_c→0.
- With yur_hazir_g=0, all yur_* outputs hold stable.
- Scoreboard set: on issue (yur_gecerli_c AND yur_hazir_g AND yur_hy_yaz_c AND yur_hy_adres_c≠0), sb[yur_hy_adres_c]←1.
- Scoreboard clear: gy_yaz_g AND gy_adres_g≠0 gives sb[gy_adres_g]←0. Set wins on a same-register collision.
- Clearing a 0 bit is a no-op.
- Flush: temizle_g=1 forces yur_gecerli_c→0 next cycle and blocks accept. The scoreboard is untouched because issued instructions always reach writeback. A flushed output-register instruction sets no bit.
- Reset has priority over flush; flush has priority over accept.

Optional Feature:
- Macro GY_ATLATMA_EN.
- Defined: if gy_yaz_g AND gy_adres_g==ky≠0, the operand takes gy_deger_g, and that register is treated as not busy via the scoreboard this cycle. A dependent instruction is therefore accepted in the same cycle as the writeback.
- Undefined: no bypass. A dependent instruction stalls until the cycle after the writeback, when the rf holds the value.

Decomposition:
- Shared package/header: `HY_BIT`, VERI_BIT, register count (1<<`HY_BIT`), x0 address constant.
- One sub-module: skor_tablosu. It holds the 2^HY_BIT-bit scoreboard with set/clear ports and exposes per-address busy lookups.

Test Plan:
- Reset with coz_gecerli_g=0 → yur_gecerli_c=0, coz_hazir_c=1, all yur_* data outputs 0.
- Issue x5←(x1,x2) and accept, then reader of x5. The reader stalls (coz_hazir_c=0) until gy_yaz_g=1, gy_adres_g=5, gy_deger_g=0x1234.
  - With EN: accepted that cycle, yur_ky1_deger_c=0x1234.
  - Without EN: accepted one cycle later with the rf value.
- Read x0 while rf returns 0xDEADBEEF → operand 0. An instruction writing x0 is never busy and sets no scoreboard bit.
- Valid output with yur_hazir_g=0 for 3 cycles → yur_* stable, coz_hazir_c=0. Releasing yur_hazir_g accepts the next instruction with no bubble.
- Two back-to-back writers of x7 → the second stalls until writeback of x7, then issues. sb[7] ends at 1.
- temizle_g=1 with a valid output register holding hy=9 → next cycle yur_gecerli_c=0, sb[9]=0, and a decode instruction presented that cycle is not accepted.
